// File: rtl/wb_port_driver_pkg.sv
// Shared write-back definitions: register numbering, queue entry layout,
// and a one-hot decode used to build the pending-write mask.
package wb_port_driver_pkg;

  localparam logic [3:0] REG_PC  = 4'd15;
  localparam int         NUM_GPR = 15;

  typedef struct packed {
    logic [3:0]  dest;
    logic [31:0] data;
  } wb_entry_t;

  // One-hot decode of a GPR number; the PC (15) decodes to all zeros.
  function automatic logic [NUM_GPR-1:0] gpr_onehot(input logic [3:0] dest);
    logic [NUM_GPR-1:0] oh;
    oh = '0;
    for (int r = 0; r < NUM_GPR; r++) oh[r] = (dest == 4'(r));
    return oh;
  endfunction

endpackage

// File: rtl/wb_port_driver_if.sv
// Producer/register-file facing signals of the write-back port driver.
interface wb_port_driver_if;
  import wb_port_driver_pkg::*;

  logic               alu_valid;
  logic [3:0]         alu_dest;
  logic [31:0]        alu_result;
  logic               mem_valid;
  logic [3:0]         mem_dest;
  logic [31:0]        mem_data;
  logic               in_ready;
  logic               writeBackEn;
  logic [3:0]         Dest_wb;
  logic [31:0]        Result_WB;
  logic               pc_write;
  logic [31:0]        pc_value;
  logic [NUM_GPR-1:0] busy_mask;
  logic               overflow;

  modport master (
    output alu_valid, alu_dest, alu_result, mem_valid, mem_dest, mem_data,
    input  in_ready, writeBackEn, Dest_wb, Result_WB, pc_write, pc_value,
           busy_mask, overflow
  );

  modport slave (
    input  alu_valid, alu_dest, alu_result, mem_valid, mem_dest, mem_data,
    output in_ready, writeBackEn, Dest_wb, Result_WB, pc_write, pc_value,
           busy_mask, overflow
  );
endinterface

// File: rtl/wb_queue.sv
// In-order circular buffer: up to two pushes and one pop per edge.
// The head is popped on every edge the queue is non-empty.
module wb_queue
  import wb_port_driver_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               push_n,   // 0, 1 or 2 entries this edge
  input  wb_entry_t                push_a,   // older entry (slot wr_ptr)
  input  wb_entry_t                push_b,   // younger entry (slot wr_ptr+1)
  output logic                     pop_vld,
  output wb_entry_t                head,
  output logic                     in_ready,
  output wb_entry_t [DEPTH-1:0]    slots,
  output logic [DEPTH-1:0]         slot_vld
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;

  assign pop_vld  = (cnt != '0);
  assign head     = slots[rd_ptr];
  // Two free slots guarantee a dual push always fits.
  assign in_ready = (cnt <= CW'(DEPTH - 2));

  // Pointer, count and storage update; pushes never touch the head slot
  // being popped because in_ready keeps two slots free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      slots  <= '0;
    end else begin
      if (push_n != 2'd0) slots[wr_ptr] <= push_a;
      if (push_n == 2'd2) slots[wr_ptr + AW'(1)] <= push_b;
      wr_ptr <= wr_ptr + AW'(push_n);
      if (pop_vld) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(push_n) - CW'(pop_vld);
    end
  end

  // A slot is live when its distance from the head is below the count.
  always_comb begin
    logic [AW-1:0] off;
    off      = '0;
    slot_vld = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off         = AW'(i) - rd_ptr;
      slot_vld[i] = ({1'b0, off} < cnt);
    end
  end

endmodule

// File: rtl/wb_port_driver.sv
// Write-back port driver: merges ALU and load results into the single
// register-file write port through wb_queue, diverts PC writes to a pulse,
// and publishes the pending-write mask for hazard detection.
module wb_port_driver
  import wb_port_driver_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  wb_port_driver_if.slave   bus
);
  logic                  in_ready, pop_vld, push_req, accept;
  logic [1:0]            push_n;
  wb_entry_t             push_a, push_b, head;
  wb_entry_t [DEPTH-1:0] slots;
  logic [DEPTH-1:0]      slot_vld;

  logic                  wb_en, pc_wr, ovf;
  logic [3:0]            wb_dest;
  logic [31:0]           wb_data, pc_val;
  logic [NUM_GPR-1:0]    busy;

  // Load result is always the older entry of a dual push. A push seen
  // while not ready is dropped as a whole.
  always_comb begin
    push_req = bus.alu_valid | bus.mem_valid;
    accept   = push_req & in_ready;
    push_n   = !accept ? 2'd0 : (bus.alu_valid & bus.mem_valid) ? 2'd2 : 2'd1;
    push_a   = bus.mem_valid ? '{dest: bus.mem_dest, data: bus.mem_data}
                             : '{dest: bus.alu_dest, data: bus.alu_result};
    push_b   = '{dest: bus.alu_dest, data: bus.alu_result};
  end

  wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk      (clk),
    .rst      (rst),
    .push_n   (push_n),
    .push_a   (push_a),
    .push_b   (push_b),
    .pop_vld  (pop_vld),
    .head     (head),
    .in_ready (in_ready),
    .slots    (slots),
    .slot_vld (slot_vld)
  );

  // Output stage: retire the head to the register file or the PC pulse.
  // Address/data hold when nothing retires.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_en   <= 1'b0;
      pc_wr   <= 1'b0;
      wb_dest <= '0;
      wb_data <= '0;
      pc_val  <= '0;
    end else if (pop_vld) begin
      if (head.dest == REG_PC) begin
        wb_en  <= 1'b0;
        pc_wr  <= 1'b1;
        pc_val <= head.data;
      end else begin
        wb_en   <= 1'b1;
        pc_wr   <= 1'b0;
        wb_dest <= head.dest;
        wb_data <= head.data;
      end
    end else begin
      wb_en <= 1'b0;
      pc_wr <= 1'b0;
    end
  end

  // Sticky record of any dropped push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      ovf <= 1'b0;
    else if (push_req & !in_ready) ovf <= 1'b1;
  end

  // Pending writes: every live queue entry plus the write in flight.
  always_comb begin
    busy = wb_en ? gpr_onehot(wb_dest) : '0;
    for (int i = 0; i < DEPTH; i++)
      if (slot_vld[i]) busy = busy | gpr_onehot(slots[i].dest);
  end

  assign bus.in_ready    = in_ready;
  assign bus.writeBackEn = wb_en;
  assign bus.Dest_wb     = wb_dest;
  assign bus.Result_WB   = wb_data;
  assign bus.pc_write    = pc_wr;
  assign bus.pc_value    = pc_val;
  assign bus.busy_mask   = busy;
  assign bus.overflow    = ovf;

endmodule

// File: tb/tb_wb_port_driver.sv
// Bench for wb_port_driver: a per-cycle vector table for the basic flows,
// then hand sequences for fill/overflow, pointer wrap and mid-drain reset.
module tb_wb_port_driver;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  wb_port_driver_if bus();
  wb_port_driver #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        av; logic [3:0] ad; logic [31:0] ar;
    logic        mv; logic [3:0] md; logic [31:0] mr;
    logic        wb; logic [3:0] dw; logic [31:0] rw;
    logic        pw; logic [31:0] pv; logic [14:0] bm; logic rdy;
  } vec_t;

  vec_t vt [13];

  function automatic vec_t mk(logic av, logic [3:0] ad, logic [31:0] ar,
                              logic mv, logic [3:0] md, logic [31:0] mr,
                              logic wb, logic [3:0] dw, logic [31:0] rw,
                              logic pw, logic [31:0] pv, logic [14:0] bm, logic rdy);
    vec_t v;
    v.av = av; v.ad = ad; v.ar = ar; v.mv = mv; v.md = md; v.mr = mr;
    v.wb = wb; v.dw = dw; v.rw = rw; v.pw = pw; v.pv = pv; v.bm = bm; v.rdy = rdy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [3:0] ad, input logic [31:0] ar,
                       input logic mv, input logic [3:0] md, input logic [31:0] mr);
    bus.alu_valid = av; bus.alu_dest = ad; bus.alu_result = ar;
    bus.mem_valid = mv; bus.mem_dest = md; bus.mem_data = mr;
  endtask

  // Inputs change at the falling edge; outputs are checked at the next one.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input logic wb, input logic [3:0] dw,
                         input logic [31:0] rw, input logic [14:0] bm, input logic rdy);
    chk({tag, ".wben"}, 32'(bus.writeBackEn), 32'(wb));
    if (wb) begin
      chk({tag, ".dest"}, 32'(bus.Dest_wb), 32'(dw));
      chk({tag, ".data"}, bus.Result_WB, rw);
    end
    chk({tag, ".busy"}, 32'(bus.busy_mask), 32'(bm));
    chk({tag, ".ready"}, 32'(bus.in_ready), 32'(rdy));
  endtask

  initial begin
    logic [31:0] exp_q [$];
    logic [3:0]  expd_q [$];
    int pushed, retired;

    vt[0]  = mk(1, 3, 32'hDEADBEEF, 0, 0, 0,     0, 0, 32'h0,        0, 32'h0,   15'h0008, 1);
    vt[1]  = mk(0, 0, 0,            0, 0, 0,     1, 3, 32'hDEADBEEF, 0, 32'h0,   15'h0008, 1);
    vt[2]  = mk(0, 0, 0,            0, 0, 0,     0, 3, 32'hDEADBEEF, 0, 32'h0,   15'h0000, 1);
    vt[3]  = mk(1, 5, 32'h22,       1, 5, 32'h11, 0, 3, 32'hDEADBEEF, 0, 32'h0,  15'h0020, 1);
    vt[4]  = mk(0, 0, 0,            0, 0, 0,     1, 5, 32'h11,       0, 32'h0,   15'h0020, 1);
    vt[5]  = mk(0, 0, 0,            0, 0, 0,     1, 5, 32'h22,       0, 32'h0,   15'h0020, 1);
    vt[6]  = mk(0, 0, 0,            0, 0, 0,     0, 5, 32'h22,       0, 32'h0,   15'h0000, 1);
    vt[7]  = mk(1, 15, 32'h100,     0, 0, 0,     0, 5, 32'h22,       0, 32'h0,   15'h0000, 1);
    vt[8]  = mk(0, 0, 0,            0, 0, 0,     0, 5, 32'h22,       1, 32'h100, 15'h0000, 1);
    vt[9]  = mk(0, 0, 0,            0, 0, 0,     0, 5, 32'h22,       0, 32'h100, 15'h0000, 1);
    vt[10] = mk(1, 15, 32'h200,     1, 1, 32'hAA, 0, 5, 32'h22,      0, 32'h100, 15'h0002, 1);
    vt[11] = mk(0, 0, 0,            0, 0, 0,     1, 1, 32'hAA,       0, 32'h100, 15'h0002, 1);
    vt[12] = mk(0, 0, 0,            0, 0, 0,     0, 1, 32'hAA,       1, 32'h200, 15'h0000, 1);

    // Reset state.
    drive(0, 0, 0, 0, 0, 0);
    #1 rst = 1'b0;
    #2;
    chk("rst.wben", 32'(bus.writeBackEn), 0);
    chk("rst.dest", 32'(bus.Dest_wb), 0);
    chk("rst.data", bus.Result_WB, 0);
    chk("rst.pcw", 32'(bus.pc_write), 0);
    chk("rst.pcv", bus.pc_value, 0);
    chk("rst.busy", 32'(bus.busy_mask), 0);
    chk("rst.ready", 32'(bus.in_ready), 1);
    chk("rst.ovf", 32'(bus.overflow), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Table: single, dual same-dest, PC diversion, mixed dual with PC.
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].av, vt[i].ad, vt[i].ar, vt[i].mv, vt[i].md, vt[i].mr);
      step();
      chk($sformatf("vec%0d.wben", i), 32'(bus.writeBackEn), 32'(vt[i].wb));
      chk($sformatf("vec%0d.dest", i), 32'(bus.Dest_wb), 32'(vt[i].dw));
      chk($sformatf("vec%0d.data", i), bus.Result_WB, vt[i].rw);
      chk($sformatf("vec%0d.pcw", i), 32'(bus.pc_write), 32'(vt[i].pw));
      chk($sformatf("vec%0d.pcv", i), bus.pc_value, vt[i].pv);
      chk($sformatf("vec%0d.busy", i), 32'(bus.busy_mask), 32'(vt[i].bm));
      chk($sformatf("vec%0d.ready", i), 32'(bus.in_ready), 32'(vt[i].rdy));
      chk($sformatf("vec%0d.ovf", i), 32'(bus.overflow), 0);
    end

    // Fill: two dual pushes reach count 3, third dual push is dropped.
    drive(1, 2, 32'h2, 1, 1, 32'h1);
    step();
    chk_out("fillA", 0, 0, 0, 15'h0006, 1);
    drive(1, 4, 32'h4, 1, 3, 32'h3);
    step();
    chk_out("fillB", 1, 1, 32'h1, 15'h001E, 0);
    drive(1, 7, 32'h7, 1, 6, 32'h6);
    step();
    chk_out("fillC", 1, 2, 32'h2, 15'h001C, 1);
    chk("fillC.ovf", 32'(bus.overflow), 1);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk_out("fillD", 1, 3, 32'h3, 15'h0018, 1);
    step();
    chk_out("fillE", 1, 4, 32'h4, 15'h0010, 1);
    step();
    chk_out("fillF", 0, 0, 0, 15'h0000, 1);
    chk("fillF.ovf", 32'(bus.overflow), 1);

    // Wrap: ten single pushes with idle gaps, scoreboard on retires.
    pushed = 0;
    retired = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (pushed == 10 && exp_q.size() == 0) break;
      if (pushed < 10 && (cyc % 3) != 2) begin
        drive(1, 4'(pushed), 32'h5000 + 32'(pushed), 0, 0, 0);
        exp_q.push_back(32'h5000 + 32'(pushed));
        expd_q.push_back(4'(pushed));
        pushed++;
      end else begin
        drive(0, 0, 0, 0, 0, 0);
      end
      step();
      if (bus.writeBackEn) begin
        if (exp_q.size() == 0) begin
          chk("wrap.unexpected", 32'(bus.writeBackEn), 0);
        end else begin
          chk($sformatf("wrap%0d.data", retired), bus.Result_WB, exp_q.pop_front());
          chk($sformatf("wrap%0d.dest", retired), 32'(bus.Dest_wb), 32'(expd_q.pop_front()));
          retired++;
        end
      end
    end
    chk("wrap.retired", 32'(retired), 10);
    chk("wrap.pending", 32'(exp_q.size()), 0);

    // Reset while three entries are queued: nothing stale retires after.
    drive(1, 8, 32'h80, 1, 7, 32'h70);
    step();
    drive(1, 10, 32'hA0, 1, 9, 32'h90);
    step();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    chk("mrst.wben", 32'(bus.writeBackEn), 0);
    chk("mrst.dest", 32'(bus.Dest_wb), 0);
    chk("mrst.data", bus.Result_WB, 0);
    chk("mrst.pcw", 32'(bus.pc_write), 0);
    chk("mrst.pcv", bus.pc_value, 0);
    chk("mrst.busy", 32'(bus.busy_mask), 0);
    chk("mrst.ready", 32'(bus.in_ready), 1);
    chk("mrst.ovf", 32'(bus.overflow), 0);
    #1 rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("post%0d.wben", i), 32'(bus.writeBackEn), 0);
      chk($sformatf("post%0d.pcw", i), 32'(bus.pc_write), 0);
      chk($sformatf("post%0d.busy", i), 32'(bus.busy_mask), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
